bus_rr_scheduler: RTL and testbench
===================================

// Module: bus_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one broadcast bus between drvrs per-device
//  FIFOs. It picks one non-empty FIFO, pops its head packet, decodes the
//  destination ID and pushes the packet into the destination FIFO(s).
//  It sits between the device-side fifo instances and the bus agents.
// PARAMETERS
//  drvrs  4    number of devices/FIFOs (2..16)
//  width  16   packet width in bits (>=16); bits [width-1:width-8] = dest ID
//  bcast  8'hFF  destination ID that means broadcast
// PORTS
//  clk        in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-high
//  pndng      in   drvrs          FIFO i non-empty
//  d_pop      in   drvrs*width    head data of FIFO i (slice i, shown while non-empty)
//  pop        out  drvrs          one-hot pop strobe to FIFO i
//  push       out  drvrs          push strobe(s) to destination FIFO(s)
//  d_push     out  width          packet driven to all FIFO inputs
//  grant      out  $clog2(drvrs)  index of the source being served
//  busy       out  1              high in any state other than IDLE
//  drop_cnt   out  8              count of dropped packets, saturates at 255
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; pop=0; push=0; d_push=0; grant=0;
//   busy=0; drop_cnt=0; rr pointer last=drvrs-1 (first grant goes to 0).
//   Any packet in flight is lost; it is not pushed and not counted.
//  FSM, all outputs registered:
//   IDLE: if pndng!=0, grant = first i with pndng[i]=1 scanning
//     last+1, last+2, ... (mod drvrs); last<=grant; go POP. Else stay.
//   POP (1 cycle): pop[grant]=1; packet register <= d_pop[grant]; go ROUTE.
//   ROUTE (1 cycle): decode id = pkt[width-1:width-8]:
//     id==bcast   -> mask = all ones except bit grant
//     id<drvrs    -> mask = one-hot(id) (self-delivery allowed)
//     otherwise   -> mask = 0, drop_cnt += 1 unless it is 255
//     go PUSH.
//   PUSH (1 cycle): push=mask; d_push=pkt; go IDLE.
//  Strobes pop/push are high for exactly one cycle per packet; push is never
//   asserted in the same cycle as pop.
//  Throughput: 4 cycles per packet (IDLE,POP,ROUTE,PUSH). Latency from
//   pndng sampled high to push high = 3 cycles.
//  Fairness: a requester that stays pending is served within drvrs packets.
//  pndng is only sampled in IDLE. Changes in other states are ignored.
//  Full destination FIFO: not checked here. The FIFO overflow policy applies.
//  d_push keeps the last packet between PUSH cycles. It is valid only when
//   push!=0.
//  bcast with drvrs=1 gives mask=0. No push, and the packet is not counted
//   as dropped.
// TESTING
//  1 reset mid-POP with pndng=4'b0001 -> pop,push,busy=0 at once; after
//    release first grant=0.
//  2 pndng=4'b0010, d_pop[1]=16'h0312 -> pop=0010 at cycle+1,
//    push=1000 with d_push=16'h0312 at cycle+3.
//  3 pndng=4'b1111 held, each FIFO 2 pkts -> grant order 0,1,2,3,0,1,2,3,
//    4 cycles apart.
//  4 FIFO2 head 16'hFF55 -> push=4'b1011, d_push=16'hFF55, drop_cnt
//    unchanged.
//  5 FIFO0 head 16'h07AA (id 7 >= drvrs) -> push stays 0, drop_cnt 0->1.
//    300 such packets -> drop_cnt=255.
//  6 pndng=0 for 50 cycles -> busy=0, pop=0, push=0 throughout.

Source files
------------

// File: rtl/bus_rr_if.sv
// Bus bundle between the round-robin scheduler and the per-device FIFOs.
// master = scheduler side, slave = FIFO/agent side.
interface bus_rr_if #(
    parameter int DRVRS = 4,
    parameter int WIDTH = 16
);
    localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    logic [DRVRS-1:0]       pndng;
    logic [DRVRS*WIDTH-1:0] d_pop;
    logic [DRVRS-1:0]       pop;
    logic [DRVRS-1:0]       push;
    logic [WIDTH-1:0]       d_push;
    logic [GW-1:0]          grant;
    logic                   busy;
    logic [7:0]             drop_cnt;

    modport master (
        input  pndng, d_pop,
        output pop, push, d_push, grant, busy, drop_cnt
    );

    modport slave (
        output pndng, d_pop,
        input  pop, push, d_push, grant, busy, drop_cnt
    );
endinterface

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler: pops one packet from a pending FIFO and pushes it to
// the FIFO(s) named by its destination ID; every packet takes 4 cycles.
module bus_rr_scheduler #(
    parameter int         DRVRS = 4,
    parameter int         WIDTH = 16,
    parameter logic [7:0] BCAST = 8'hFF
) (
    input  logic      clk,
    input  logic      reset,
    bus_rr_if.master  bus
);
    localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic [1:0] {IDLE, POP, ROUTE, PUSH} state_t;

    state_t           state_q, state_d;
    logic [DRVRS-1:0] pop_q, pop_d;
    logic [DRVRS-1:0] push_q, push_d;
    logic [WIDTH-1:0] pkt_q, pkt_d;
    logic [WIDTH-1:0] d_push_q, d_push_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q, last_d;
    logic             busy_q, busy_d;
    logic [7:0]       drop_q, drop_d;

    logic [WIDTH-1:0] head [DRVRS];
    logic [GW-1:0]    sel, idx;
    logic             found;
    logic [7:0]       id;
    logic [DRVRS-1:0] mask;
    logic             drop;

    for (genvar g = 0; g < DRVRS; g++) begin : g_head
        assign head[g] = bus.d_pop[g*WIDTH +: WIDTH];
    end

    // First pending requester scanning from the slot after the last grant.
    always_comb begin
        sel   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= DRVRS; i++) begin
            idx = GW'((int'(last_q) + i) % DRVRS);
            if (!found && bus.pndng[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        id   = pkt_q[WIDTH-1 -: 8];
        mask = '0;
        drop = 1'b0;
        if (id == BCAST) begin
            mask = ~(DRVRS'(1) << grant_q);
        end else if (int'(id) < DRVRS) begin
            mask[id[GW-1:0]] = 1'b1;
        end else begin
            drop = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pop_d    = '0;
        push_d   = '0;
        pkt_d    = pkt_q;
        d_push_d = d_push_q;
        grant_d  = grant_q;
        last_d   = last_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = sel;
                    last_d  = sel;
                    pop_d   = DRVRS'(1) << sel;
                    state_d = POP;
                end
            end
            POP: begin
                pkt_d   = head[grant_q];
                state_d = ROUTE;
            end
            ROUTE: begin
                push_d   = mask;
                d_push_d = pkt_q;
                if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                state_d  = PUSH;
            end
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pop_q    <= '0;
            push_q   <= '0;
            pkt_q    <= '0;
            d_push_q <= '0;
            grant_q  <= '0;
            last_q   <= GW'(DRVRS - 1);
            busy_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            pkt_q    <= pkt_d;
            d_push_q <= d_push_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.pop      = pop_q;
    assign bus.push     = push_q;
    assign bus.d_push   = d_push_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler: emulates the device FIFOs and predicts every
// output cycle by cycle from a packet-level schedule model.
module tb_bus_rr_scheduler;
    localparam int         N  = 4;
    localparam int         W  = 16;
    localparam logic [7:0] BC = 8'hFF;
    localparam int         DEPTH = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_rr_if #(.DRVRS(N), .WIDTH(W)) bus ();

    bus_rr_scheduler #(.DRVRS(N), .WIDTH(W), .BCAST(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // FIFO emulation
    logic [W-1:0] mem [N][DEPTH];
    int           wr [N];
    int           rd [N];
    logic [N-1:0] pop_seen;

    // expectation ring, indexed by cycle number mod 16
    logic [N-1:0] r_pop  [16];
    logic [N-1:0] r_push [16];
    logic [W-1:0] r_dat  [16];
    logic         r_busy [16];
    int           r_g    [16];
    logic         r_inc  [16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_last, m_grant, m_drop, m_free;

    int log_g [16];
    int log_c [16];
    int nlog;
    logic log_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic load(input int f, input logic [W-1:0] pkt);
        mem[f][wr[f] % DEPTH] = pkt;
        wr[f]++;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            r_pop[s] = '0; r_push[s] = '0; r_dat[s] = '0;
            r_busy[s] = 1'b0; r_g[s] = -1; r_inc[s] = 1'b0;
        end
        m_last  = N - 1;
        m_grant = 0;
        m_drop  = 0;
        m_free  = cyc;
    endtask

    task automatic step();
        logic [N-1:0] pend;
        logic [N-1:0] mask;
        logic [W-1:0] pkt;
        int g, id, s;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (pop_seen[i] && rd[i] != wr[i]) rd[i]++;
        for (int i = 0; i < N; i++) begin
            pend[i] = (rd[i] != wr[i]);
            bus.d_pop[i*W +: W] = pend[i] ? mem[i][rd[i] % DEPTH] : '0;
        end
        bus.pndng = pend;
        // a free scheduler samples pndng at the coming edge and serves one packet
        if (cyc >= m_free && pend != '0) begin
            g = -1;
            for (int j = 1; j <= N; j++)
                if (g < 0 && pend[(m_last + j) % N]) g = (m_last + j) % N;
            m_last = g;
            pkt = mem[g][rd[g] % DEPTH];
            id  = int'(pkt[W-1 -: 8]);
            mask = '0;
            if (id == int'(BC)) begin
                mask = '1;
                mask[g] = 1'b0;
            end else if (id < N) begin
                mask[id] = 1'b1;
            end
            r_pop[(cyc+1)%16]  = '0;
            r_pop[(cyc+1)%16][g] = 1'b1;
            r_g[(cyc+1)%16]    = g;
            r_busy[(cyc+1)%16] = 1'b1;
            r_busy[(cyc+2)%16] = 1'b1;
            r_busy[(cyc+3)%16] = 1'b1;
            r_push[(cyc+3)%16] = mask;
            r_dat[(cyc+3)%16]  = pkt;
            r_inc[(cyc+3)%16]  = (id != int'(BC)) && (id >= N);
            m_free = cyc + 4;
        end
        @(negedge clk);
        s = cyc % 16;
        if (r_g[s] >= 0) m_grant = r_g[s];
        if (r_inc[s] && m_drop < 255) m_drop++;
        chk("pop", 32'(bus.pop), 32'(r_pop[s]));
        chk("push", 32'(bus.push), 32'(r_push[s]));
        chk("busy", 32'(bus.busy), 32'(r_busy[s]));
        chk("grant", 32'(bus.grant), 32'(m_grant));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        if (r_push[s] != '0) chk("d_push", 32'(bus.d_push), 32'(r_dat[s]));
        if (log_en && bus.pop != '0 && nlog < 16) begin
            log_g[nlog] = int'(bus.grant);
            log_c[nlog] = cyc;
            nlog++;
        end
        pop_seen = bus.pop;
        r_pop[s] = '0; r_push[s] = '0; r_busy[s] = 1'b0; r_g[s] = -1; r_inc[s] = 1'b0;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // called just after a falling edge; reset lands mid-cycle
    task automatic reset_dut();
        #1 reset = 1'b1;
        bus.pndng = '0;
        bus.d_pop = '0;
        #1;
        chk("rst_pop", 32'(bus.pop), 32'd0);
        chk("rst_push", 32'(bus.push), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pop_seen = '0;
        model_reset();
    endtask

    initial begin
        int r, f, idv;
        reset = 1'b1;
        bus.pndng = '0;
        bus.d_pop = '0;
        pop_seen = '0;
        for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; end
        @(negedge clk);
        reset_dut();

        // 1: reset while FIFO0 is being popped; FIFO3 waiting too
        load(0, 16'h0011);
        steps(2);
        chk("t1_pop_before", 32'(bus.pop), 32'h1);
        load(3, 16'h0122);
        reset_dut();
        steps(2);
        chk("t1_first_grant", 32'(bus.grant), 32'd0);
        chk("t1_first_pop", 32'(bus.pop), 32'h1);
        steps(8);

        // 3: all FIFOs pending with two packets each
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) load(i, {8'(k), 8'($urandom)});
        nlog = 0;
        log_en = 1'b1;
        steps(40);
        log_en = 1'b0;
        chk("t3_npops", 32'(nlog), 32'd8);
        for (int k = 0; k < 8; k++) chk("t3_order", 32'(log_g[k]), 32'(k % 4));
        for (int k = 1; k < 8; k++) chk("t3_spacing", 32'(log_c[k] - log_c[k-1]), 32'd4);

        // 2: unicast to device 3
        load(1, 16'h0312);
        steps(2);
        chk("t2_pop", 32'(bus.pop), 32'h2);
        steps(2);
        chk("t2_push", 32'(bus.push), 32'h8);
        chk("t2_d_push", 32'(bus.d_push), 32'h0312);
        steps(4);

        // 4: broadcast from FIFO2
        load(2, 16'hFF55);
        steps(4);
        chk("t4_push", 32'(bus.push), 32'hB);
        chk("t4_d_push", 32'(bus.d_push), 32'hFF55);
        chk("t4_drop", 32'(bus.drop_cnt), 32'd0);
        steps(4);

        // 5: out-of-range destination, then saturation
        load(0, 16'h07AA);
        steps(4);
        chk("t5_push", 32'(bus.push), 32'd0);
        chk("t5_drop1", 32'(bus.drop_cnt), 32'd1);
        for (int k = 0; k < 300; k++) load(0, 16'h07AA);
        steps(1220);
        chk("t5_drop_sat", 32'(bus.drop_cnt), 32'd255);

        // randomized traffic from a fresh reset
        reset_dut();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                f = $urandom_range(0, N-1);
                r = $urandom_range(0, 9);
                if (r < 6)      idv = $urandom_range(0, N-1);
                else if (r < 8) idv = int'(BC);
                else            idv = $urandom_range(N, 254);
                load(f, {8'(idv), 8'($urandom)});
            end
            step();
        end
        steps(400);

        // 6: idle for 50 cycles
        for (int k = 0; k < 50; k++) begin
            step();
            chk("t6_busy", 32'(bus.busy), 32'd0);
            chk("t6_pop", 32'(bus.pop), 32'd0);
            chk("t6_push", 32'(bus.push), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
